// File: rtl/alu_mc_if.sv
// Request/response bundle for alu_mc: a valid/ready request side
// (operation and operands) and a valid/ready result side.
interface alu_mc_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            out_illegal;

    modport master (
        output in_valid, alu_op, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, out_illegal
    );

    modport slave (
        input  in_valid, alu_op, op_a, op_b, out_ready,
        output in_ready, out_valid, result, out_illegal
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare ops, iterative
// shift-add MUL (XLEN cycles), one-entry result register with backpressure.
module alu_mc #(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1
) (
    input logic   clk,
    input logic   rst_n,
    alu_mc_if.slave bus
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND = 4'b0010,
        OP_OR   = 4'b0011, OP_XOR  = 4'b0100, OP_SLL = 4'b0101,
        OP_SRL  = 4'b0110, OP_SRA  = 4'b0111, OP_SLT = 4'b1000,
        OP_SLTU = 4'b1001, OP_MUL  = 4'b1010
    } op_e;

    state_e          state, state_d;
    logic [XLEN-1:0] alu_res, result_q;
    logic [XLEN-1:0] acc, acc_next, mcand, mplier;
    logic [SW-1:0]   cnt, shamt;
    logic            illegal_q, is_mul, is_illegal, accept, last_bit;
    logic            in_ready_c, out_valid_c;

    assign shamt      = bus.op_b[SW-1:0];
    assign is_mul     = (MUL_EN != 0) && (bus.alu_op == OP_MUL);
    assign is_illegal = (bus.alu_op > OP_MUL) || ((MUL_EN == 0) && (bus.alu_op == OP_MUL));
    assign accept     = bus.in_valid && in_ready_c;
    assign last_bit   = (cnt == SW'(XLEN - 1));
    assign acc_next   = mplier[0] ? acc + mcand : acc;

    // Illegal codes (and MUL, handled iteratively) fall through to zero.
    always_comb begin
        alu_res = '0;
        case (bus.alu_op)
            OP_ADD:  alu_res = bus.op_a + bus.op_b;
            OP_SUB:  alu_res = bus.op_a - bus.op_b;
            OP_AND:  alu_res = bus.op_a & bus.op_b;
            OP_OR:   alu_res = bus.op_a | bus.op_b;
            OP_XOR:  alu_res = bus.op_a ^ bus.op_b;
            OP_SLL:  alu_res = bus.op_a << shamt;
            OP_SRL:  alu_res = bus.op_a >> shamt;
            OP_SRA:  alu_res = $signed(bus.op_a) >>> shamt;
            OP_SLT:  alu_res[0] = $signed(bus.op_a) < $signed(bus.op_b);
            OP_SLTU: alu_res[0] = bus.op_a < bus.op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = is_mul ? MUL : DONE;
            end
            MUL: begin
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    in_ready_c = 1'b1;
                    if (bus.in_valid) state_d = is_mul ? MUL : DONE;
                    else              state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q  <= '0;
            illegal_q <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= bus.op_a;
                mplier <= bus.op_b;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                result_q  <= alu_res;
                illegal_q <= is_illegal;
            end
        end else if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                result_q  <= acc_next;
                illegal_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_c;
    assign bus.result      = result_q;
    assign bus.out_illegal = illegal_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (XLEN=32, MUL_EN=1).
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_mc_if #(.XLEN(32)) bus ();

    alu_mc #(.XLEN(32), .MUL_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.op_a     = a;
        bus.op_b     = b;
    endtask

    // Inputs are scrambled right after accept; the held result must not move.
    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.alu_op   = 4'h0;
        bus.op_a     = 32'hDEAD_BEEF;
        bus.op_b     = 32'h1357_9BDF;
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic ill);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        drive(op, a, b);
        bus.out_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".result"}, bus.result, exp);
        chk({tag, ".illegal"}, 32'(bus.out_illegal), 32'(ill));
        @(negedge clk);
        chk({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        int unsigned n;
        int unsigned busy_bad;
        drive(4'b1010, a, b);
        bus.out_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        n = 1;
        busy_bad = 0;
        while (!bus.out_valid && n < 100) begin
            if (bus.in_ready) busy_bad++;
            @(negedge clk);
            n++;
        end
        // Drive at negedge N0, accept at the next posedge; done 32 edges later.
        chk({tag, ".latency"}, n, 32'd33);
        chk({tag, ".busy_ready"}, busy_bad, 32'd0);
        chk({tag, ".result"}, bus.result, exp);
        chk({tag, ".illegal"}, 32'(bus.out_illegal), 32'd0);
        @(negedge clk);
        chk({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int unsigned seen;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_op    = 4'h0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.result", bus.result, 32'd0);
        chk("rst.illegal", 32'(bus.out_illegal), 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);

        single("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
        single("sub_wrap", 4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        single("and",      4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
        single("or",       4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
        single("xor",      4'b0100, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 1'b0);
        single("sra_neg",  4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0);
        single("sra_pos",  4'b0111, 32'h7FFF_FFFF, 32'h0000_0004, 32'h07FF_FFFF, 1'b0);
        single("sll_mask", 4'b0101, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0);
        single("srl_31",   4'b0110, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0);
        single("slt",      4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
        single("slt_rev",  4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        single("sltu",     4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
        single("ill_f",    4'b1111, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1);
        single("ill_b",    4'b1011, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1);
        single("add_legal_after_ill", 4'b0000, 32'h0000_0005, 32'h0000_0006, 32'h0000_000B, 1'b0);

        mul("mul_a", 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
        mul("mul_b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

        // Back-to-back single-cycle ops with out_ready held high.
        bus.out_ready = 1'b1;
        drive(4'b0000, 32'd1, 32'd2);
        @(negedge clk);
        chk("b2b1.valid", 32'(bus.out_valid), 32'd1);
        chk("b2b1.result", bus.result, 32'd3);
        chk("b2b1.ready", 32'(bus.in_ready), 32'd1);
        drive(4'b0001, 32'd10, 32'd3);
        @(negedge clk);
        chk("b2b2.valid", 32'(bus.out_valid), 32'd1);
        chk("b2b2.result", bus.result, 32'd7);
        drive(4'b0100, 32'h0000_00AA, 32'h0000_0005);
        @(negedge clk);
        idle_inputs();
        chk("b2b3.valid", 32'(bus.out_valid), 32'd1);
        chk("b2b3.result", bus.result, 32'h0000_00AF);
        @(negedge clk);
        chk("b2b.drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: hold 3+4 for three cycles, then transfer and accept XOR.
        bus.out_ready = 1'b0;
        drive(4'b0000, 32'd3, 32'd4);
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("bp.valid", 32'(bus.out_valid), 32'd1);
            chk("bp.result", bus.result, 32'd7);
            chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
            if (i < 2) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        drive(4'b0100, 32'h0000_00F0, 32'h0000_00FF);
        #1;
        chk("bp.release_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        idle_inputs();
        chk("bp.xor_valid", 32'(bus.out_valid), 32'd1);
        chk("bp.xor_result", bus.result, 32'h0000_000F);
        @(negedge clk);
        chk("bp.drained", 32'(bus.out_valid), 32'd0);

        // Reset 10 cycles into a MUL; a request offered during reset is ignored.
        drive(4'b1010, 32'h0000_0003, 32'h0000_0005);
        @(negedge clk);
        idle_inputs();
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        drive(4'b0000, 32'd5, 32'd5);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        chk("rstmul.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rstmul.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rstmul.result", bus.result, 32'd0);
        chk("rstmul.illegal", 32'(bus.out_illegal), 32'd0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("rstmul.no_output", seen, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
